// File: rtl/clkman_pkg.sv
// clkman_pkg: shared width, configuration struct and channel state encoding for the clock-enable manager
package clkman_pkg;
    localparam int CLKMAN_WIDTH = 16;
    typedef struct packed {
        logic                    en;
        logic [CLKMAN_WIDTH-1:0] div;
    } clkdiv_cfg_t;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, RUN_PEND = 2'd2} clkdiv_state_t;
endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divided timebase with pending-divisor handoff at terminal count
module clkdiv_channel
    import clkman_pkg::*;
#(
    parameter type cfg_t = clkdiv_cfg_t
) (
    input  logic clock,
    input  logic reset,
    input  logic wr,
    input  cfg_t cfg,
    input  logic sync,
    output logic ce,
    output logic tog,
    output logic locked
);
    localparam int W = $bits(cfg_t) - 1;
    logic          en;
    logic          pend_valid;
    logic [W-1:0]  active_div;
    logic [W-1:0]  pend_div;
    logic [W-1:0]  count;
    logic [W-1:0]  next_div;
    logic          tc;
    clkdiv_state_t st;
    always_comb begin
        st       = !en ? IDLE : pend_valid ? RUN_PEND : RUN;
        next_div = (st == RUN_PEND) ? pend_div : active_div;
        tc       = (count == '0);
    end
    always_ff @(posedge clock) begin
        if (reset || (wr && !cfg.en)) begin
            en         <= 1'b0;
            pend_valid <= 1'b0;
            active_div <= '0;
            pend_div   <= '0;
            count      <= '0;
            ce         <= 1'b0;
            tog        <= 1'b0;
            locked     <= 1'b0;
        end else if (st == IDLE) begin
            if (wr) begin
                en         <= 1'b1;
                active_div <= cfg.div;
                count      <= cfg.div;
            end
        end else if (sync) begin
            // a write in the same cycle bypasses the pending register
            active_div <= wr ? cfg.div : next_div;
            count      <= wr ? cfg.div : next_div;
            pend_valid <= 1'b0;
            ce         <= 1'b0;
            tog        <= 1'b0;
            locked     <= wr ? 1'b0 : locked;
        end else begin
            ce         <= tc;
            tog        <= tc ? ~tog : tog;
            count      <= tc ? next_div : count - 1'b1;
            active_div <= tc ? next_div : active_div;
            locked     <= wr ? 1'b0 : (locked | (tc & ~pend_valid));
            pend_div   <= wr ? cfg.div : pend_div;
            pend_valid <= wr | (pend_valid & ~tc);
        end
    end
endmodule

// File: rtl/clkdiv_manager.sv
// clkdiv_manager: CHANNELS independent programmable clock-enable generators sharing one config port
module clkdiv_manager
    import clkman_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = CLKMAN_WIDTH,
    parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_wr,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic                cfg_en,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                sync,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] tog,
    output logic [CHANNELS-1:0] locked
);
    typedef struct packed {
        logic             en;
        logic [WIDTH-1:0] div;
    } cfg_t;
    cfg_t cfg;
    assign cfg = {cfg_en, cfg_div};
    // out-of-range selects match no channel, so those writes fall away
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clkdiv_channel #(.cfg_t(cfg_t)) u_ch (
            .clock  (clock),
            .reset  (reset),
            .wr     (cfg_wr && (cfg_sel == SEL_W'(i))),
            .cfg    (cfg),
            .sync   (sync),
            .ce     (ce[i]),
            .tog    (tog[i]),
            .locked (locked[i])
        );
    end
endmodule

// File: tb/tb_clkdiv_manager.sv
// tb_clkdiv_manager: timestamp-based reference model feeding a scoreboard checked every cycle
module tb_clkdiv_manager;
    localparam int CH = 3;
    localparam int W  = 16;
    localparam int SW = 2;
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_wr = 1'b0;
    logic [SW-1:0] cfg_sel = '0;
    logic          cfg_en = 1'b0;
    logic [W-1:0]  cfg_div = '0;
    logic          sync = 1'b0;
    logic [CH-1:0] ce;
    logic [CH-1:0] tog;
    logic [CH-1:0] locked;
    always #5 clock = ~clock;
    clkdiv_manager #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .cfg_wr  (cfg_wr),
        .cfg_sel (cfg_sel),
        .cfg_en  (cfg_en),
        .cfg_div (cfg_div),
        .sync    (sync),
        .ce      (ce),
        .tog     (tog),
        .locked  (locked)
    );
    typedef struct packed {
        logic [CH-1:0] ce;
        logic [CH-1:0] tog;
        logic [CH-1:0] locked;
    } exp_t;
    exp_t   q[$];
    int     n_chk = 0;
    int     n_fail = 0;
    longint edge_n = 0;
    // model: each running channel is described by the absolute edge of its next terminal count
    bit     m_en[CH];
    bit     m_pv[CH];
    bit     m_ce[CH];
    bit     m_tog[CH];
    bit     m_lk[CH];
    int     m_cur[CH];
    int     m_pend[CH];
    longint m_due[CH];
    always @(posedge clock) begin
        exp_t e;
        bit   w;
        int   d;
        edge_n++;
        for (int c = 0; c < CH; c++) begin
            w = cfg_wr && (int'(cfg_sel) == c);
            d = int'(cfg_div);
            if (reset || (w && !cfg_en)) begin
                m_en[c] = 0; m_pv[c] = 0; m_ce[c] = 0; m_tog[c] = 0; m_lk[c] = 0;
            end else if (!m_en[c]) begin
                if (w) begin
                    m_en[c] = 1; m_cur[c] = d; m_due[c] = edge_n + d + 1;
                end
            end else if (sync) begin
                if (!w) d = m_pv[c] ? m_pend[c] : m_cur[c];
                m_cur[c] = d; m_pv[c] = 0; m_ce[c] = 0; m_tog[c] = 0;
                if (w) m_lk[c] = 0;
                m_due[c] = edge_n + d + 1;
            end else begin
                m_ce[c] = (edge_n == m_due[c]);
                if (m_ce[c]) begin
                    m_tog[c] = !m_tog[c];
                    if (!m_pv[c]) m_lk[c] = 1;
                    if (m_pv[c]) m_cur[c] = m_pend[c];
                    m_pv[c] = 0;
                    m_due[c] = edge_n + m_cur[c] + 1;
                end
                if (w) begin
                    m_pend[c] = d; m_pv[c] = 1; m_lk[c] = 0;
                end
            end
            e.ce[c] = m_ce[c]; e.tog[c] = m_tog[c]; e.locked[c] = m_lk[c];
        end
        q.push_back(e);
    end
    task automatic check(input string nm, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %b expected %b", nm, edge_n, got, exp);
        end
    endtask
    always @(negedge clock) begin
        exp_t e;
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard at edge %0d: got empty queue expected an entry", edge_n);
        end else begin
            e = q.pop_front();
            check("ce", ce, e.ce);
            check("tog", tog, e.tog);
            check("locked", locked, e.locked);
        end
    end
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic wr(input int ch, input bit en, input int d);
        cfg_wr = 1'b1; cfg_sel = SW'(ch); cfg_en = en; cfg_div = W'(d);
        step(1);
        cfg_wr = 1'b0;
    endtask
    initial begin
        step(3);
        reset = 1'b0;
        step(2);
        wr(0, 1, 3);
        step(14);
        step(2);
        wr(0, 1, 1);
        step(12);
        wr(0, 0, 0);
        wr(0, 1, 2);
        wr(1, 1, 2);
        step(5);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        step(12);
        wr(2, 1, 0);
        step(6);
        wr(2, 0, 0);
        step(3);
        sync = 1'b1;
        wr(1, 1, 5);
        sync = 1'b0;
        step(14);
        wr(3, 1, 4);
        wr(3, 0, 0);
        step(5);
        wr(0, 1, 6);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(10);
        for (int k = 0; k < 600; k++) begin
            cfg_wr  = ($urandom_range(11) == 0);
            cfg_sel = SW'($urandom_range(3));
            cfg_en  = ($urandom_range(5) != 0);
            cfg_div = W'($urandom_range(7));
            sync    = ($urandom_range(15) == 0);
            reset   = ($urandom_range(249) == 0);
            step(1);
        end
        cfg_wr = 1'b0; sync = 1'b0; reset = 1'b0;
        step(3);
        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
